// File: rtl/morse_char_encoder_pkg.sv
// rtl/morse_char_encoder_pkg.sv - shared FSM codes, ITU unit counts and helpers for the Morse encoder
package morse_char_encoder_pkg;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_LOOKUP   = 3'd1;
    localparam logic [2:0] ST_MARK     = 3'd2;
    localparam logic [2:0] ST_ELEM_GAP = 3'd3;
    localparam logic [2:0] ST_CHAR_GAP = 3'd4;
    localparam logic [2:0] ST_WORD_GAP = 3'd5;

    localparam int DOT_UNITS      = 1;
    localparam int DASH_UNITS     = 3;
    localparam int ELEM_GAP_UNITS = 1;
    localparam int CHAR_GAP_UNITS = 3;
    localparam int WORD_GAP_UNITS = 4;

    typedef struct packed {
        logic       valid;
        logic [2:0] len;
        logic [4:0] pat;
    } morse_code_t;

    function automatic morse_code_t mc(input logic [2:0] len, input logic [4:0] pat);
        morse_code_t c;
        c.valid = 1'b1;
        c.len   = len;
        c.pat   = pat;
        return c;
    endfunction

    function automatic logic [7:0] fold_case(input logic [7:0] ch);
        if (ch >= 8'h61 && ch <= 8'h7A)
            return ch & 8'hDF;
        return ch;
    endfunction

    function automatic logic dash_at(input logic [4:0] pat, input logic [2:0] idx);
        logic [4:0] sh;
        sh = pat >> idx;
        return sh[0];
    endfunction

    // A 2-bit load of 4 wraps to 0; counting 0,3,2,1 still yields four ticks.
    function automatic logic [1:0] units_load(input int units);
        return 2'(units);
    endfunction

endpackage

// File: rtl/morse_rom.sv
// rtl/morse_rom.sv - combinational ASCII to Morse lookup; pattern right-aligned, 1 = dash
module morse_rom
    import morse_char_encoder_pkg::*;
(
    input  logic [7:0] ch,
    output logic [2:0] len,
    output logic [4:0] pat,
    output logic       valid
);

    logic [7:0]  up;
    morse_code_t code;

    always_comb begin
        up   = fold_case(ch);
        code = '0;
        case (up)
            8'h20: code = mc(3'd0, 5'b00000);
            8'h41: code = mc(3'd2, 5'b00001);
            8'h42: code = mc(3'd4, 5'b01000);
            8'h43: code = mc(3'd4, 5'b01010);
            8'h44: code = mc(3'd3, 5'b00100);
            8'h45: code = mc(3'd1, 5'b00000);
            8'h46: code = mc(3'd4, 5'b00010);
            8'h47: code = mc(3'd3, 5'b00110);
            8'h48: code = mc(3'd4, 5'b00000);
            8'h49: code = mc(3'd2, 5'b00000);
            8'h4A: code = mc(3'd4, 5'b00111);
            8'h4B: code = mc(3'd3, 5'b00101);
            8'h4C: code = mc(3'd4, 5'b00100);
            8'h4D: code = mc(3'd2, 5'b00011);
            8'h4E: code = mc(3'd2, 5'b00010);
            8'h4F: code = mc(3'd3, 5'b00111);
            8'h50: code = mc(3'd4, 5'b00110);
            8'h51: code = mc(3'd4, 5'b01101);
            8'h52: code = mc(3'd3, 5'b00010);
            8'h53: code = mc(3'd3, 5'b00000);
            8'h54: code = mc(3'd1, 5'b00001);
            8'h55: code = mc(3'd3, 5'b00001);
            8'h56: code = mc(3'd4, 5'b00001);
            8'h57: code = mc(3'd3, 5'b00011);
            8'h58: code = mc(3'd4, 5'b01001);
            8'h59: code = mc(3'd4, 5'b01011);
            8'h5A: code = mc(3'd4, 5'b01100);
            8'h30: code = mc(3'd5, 5'b11111);
            8'h31: code = mc(3'd5, 5'b01111);
            8'h32: code = mc(3'd5, 5'b00111);
            8'h33: code = mc(3'd5, 5'b00011);
            8'h34: code = mc(3'd5, 5'b00001);
            8'h35: code = mc(3'd5, 5'b00000);
            8'h36: code = mc(3'd5, 5'b10000);
            8'h37: code = mc(3'd5, 5'b11000);
            8'h38: code = mc(3'd5, 5'b11100);
            8'h39: code = mc(3'd5, 5'b11110);
            default: code = '0;
        endcase
    end

    assign len   = code.len;
    assign pat   = code.pat;
    assign valid = code.valid;

endmodule

// File: rtl/morse_char_encoder.sv
// rtl/morse_char_encoder.sv - one-character-at-a-time Morse player driving an active-low LED
module morse_char_encoder
    import morse_char_encoder_pkg::*;
#(
    parameter int unsigned UNIT_CYCLES = 24'h493E00,
    parameter int          CNT_W       = 24
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       char_valid,
    input  logic [7:0] char_data,
    output logic       char_ready,
    output logic       led_n,
    output logic       busy,
    output logic       char_err
);

    logic [2:0]       state, state_nx;
    logic [7:0]       char_q;
    logic [2:0]       idx, idx_nx;
    logic [CNT_W-1:0] unit_cnt;
    logic [1:0]       units_left, units_ld;
    logic             tick, last_tick, enter;
    logic [2:0]       rom_len;
    logic [4:0]       rom_pat;
    logic             rom_valid;

    morse_rom u_rom (
        .ch    (char_q),
        .len   (rom_len),
        .pat   (rom_pat),
        .valid (rom_valid)
    );

    assign tick       = (unit_cnt == CNT_W'(UNIT_CYCLES - 1));
    assign last_tick  = tick && (units_left == 2'd1);
    assign char_ready = (state == ST_IDLE);
    assign busy       = (state != ST_IDLE);
    assign char_err   = (state == ST_LOOKUP) && !rom_valid;
    assign enter      = (state_nx != state);

    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        units_ld = 2'd0;
        case (state)
            ST_IDLE: begin
                if (char_valid)
                    state_nx = ST_LOOKUP;
            end
            ST_LOOKUP: begin
                if (!rom_valid) begin
                    state_nx = ST_IDLE;
                end else if (rom_len == 3'd0) begin
                    state_nx = ST_WORD_GAP;
                    units_ld = units_load(WORD_GAP_UNITS);
                end else begin
                    state_nx = ST_MARK;
                    idx_nx   = rom_len - 3'd1;
                    units_ld = dash_at(rom_pat, rom_len - 3'd1) ? units_load(DASH_UNITS)
                                                                : units_load(DOT_UNITS);
                end
            end
            ST_MARK: begin
                if (last_tick) begin
                    if (idx == 3'd0) begin
                        state_nx = ST_CHAR_GAP;
                        units_ld = units_load(CHAR_GAP_UNITS);
                    end else begin
                        state_nx = ST_ELEM_GAP;
                        units_ld = units_load(ELEM_GAP_UNITS);
                    end
                end
            end
            ST_ELEM_GAP: begin
                if (last_tick) begin
                    state_nx = ST_MARK;
                    idx_nx   = idx - 3'd1;
                    units_ld = dash_at(rom_pat, idx - 3'd1) ? units_load(DASH_UNITS)
                                                            : units_load(DOT_UNITS);
                end
            end
            ST_CHAR_GAP, ST_WORD_GAP: begin
                if (last_tick)
                    state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // led_n follows the next state so it changes on the same edge as the FSM, glitch-free.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            char_q     <= 8'h00;
            idx        <= 3'd0;
            unit_cnt   <= '0;
            units_left <= 2'd0;
            led_n      <= 1'b1;
        end else begin
            state <= state_nx;
            idx   <= idx_nx;
            led_n <= (state_nx != ST_MARK);
            if (char_valid && char_ready)
                char_q <= char_data;
            if (enter) begin
                unit_cnt   <= '0;
                units_left <= units_ld;
            end else if (state == ST_IDLE || state == ST_LOOKUP || tick) begin
                unit_cnt   <= '0;
                if (tick)
                    units_left <= units_left - 2'd1;
            end else begin
                unit_cnt <= unit_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_morse_char_encoder.sv
// tb/tb_morse_char_encoder.sv - directed self-checking bench for morse_char_encoder with 4-clock units
module tb_morse_char_encoder;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       char_valid = 1'b0;
    logic [7:0] char_data = 8'h00;
    logic       char_ready, led_n, busy, char_err;

    int checks = 0;
    int errors = 0;
    int run_q[$];
    int err_seen;
    logic first_led, first_busy;

    morse_char_encoder #(.UNIT_CYCLES(4), .CNT_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .char_valid (char_valid),
        .char_data  (char_data),
        .char_ready (char_ready),
        .led_n      (led_n),
        .busy       (busy),
        .char_err   (char_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Runs of constant led_n sampled at negedges, from the cycle after the accept edge until char_ready returns.
    task automatic play(input logic [7:0] c, input bit hold_valid);
        int guard;
        int len;
        logic cur;
        guard = 0;
        while (!char_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("ready_before_accept", int'(char_ready), 1);
        char_data  = c;
        char_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if (!hold_valid)
            char_valid = 1'b0;
        run_q.delete();
        err_seen   = 0;
        first_led  = led_n;
        first_busy = busy;
        cur        = led_n;
        len        = 0;
        guard      = 0;
        while (!char_ready && guard < 400) begin
            err_seen += int'(char_err);
            if (led_n == cur) begin
                len++;
            end else begin
                run_q.push_back(len);
                cur = led_n;
                len = 1;
            end
            @(negedge clk);
            guard++;
        end
        run_q.push_back(len);
        check("play_timeout", int'(guard < 400), 1);
    endtask

    task automatic expect_runs(input string tag, input int exp[$], input int exp_err);
        check({tag, "_first_led"}, int'(first_led), 1);
        check({tag, "_busy"}, int'(first_busy), 1);
        check({tag, "_err"}, err_seen, exp_err);
        check({tag, "_nruns"}, run_q.size(), exp.size());
        for (int i = 0; i < exp.size() && i < run_q.size(); i++)
            check($sformatf("%s_run%0d", tag, i), run_q[i], exp[i]);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_led_n", int'(led_n), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_char_err", int'(char_err), 0);
        rst = 1'b1;
        @(negedge clk);
        check("rst_char_ready", int'(char_ready), 1);

        play(8'h45, 1'b0);
        expect_runs("E", '{1, 4, 12}, 0);

        play(8'h61, 1'b0);
        expect_runs("a", '{1, 4, 4, 12, 12}, 0);

        play(8'h53, 1'b1);
        expect_runs("S1", '{1, 4, 4, 4, 4, 4, 12}, 0);
        play(8'h4F, 1'b1);
        expect_runs("O", '{1, 12, 4, 12, 4, 12, 12}, 0);
        play(8'h53, 1'b0);
        expect_runs("S2", '{1, 4, 4, 4, 4, 4, 12}, 0);

        play(8'h54, 1'b0);
        expect_runs("T", '{1, 12, 12}, 0);
        play(8'h20, 1'b0);
        check("space_nruns", run_q.size(), 1);
        check("space_high", run_q[0], 17);
        check("space_led", int'(first_led), 1);
        check("space_err", err_seen, 0);

        play(8'h23, 1'b0);
        check("hash_err", err_seen, 1);
        check("hash_nruns", run_q.size(), 1);
        check("hash_len", run_q[0], 1);
        check("hash_led", int'(first_led), 1);

        play(8'h7B, 1'b0);
        check("brace_err", err_seen, 1);
        check("brace_len", run_q[0], 1);

        play(8'h39, 1'b0);
        expect_runs("9", '{1, 12, 4, 12, 4, 12, 4, 12, 4, 4, 12}, 0);

        play(8'h7A, 1'b0);
        expect_runs("z", '{1, 12, 4, 12, 4, 4, 4, 4, 12}, 0);

        // Abort '0' in the middle of its second dash.
        char_data  = 8'h30;
        char_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        char_valid = 1'b0;
        repeat (20) @(negedge clk);
        check("zero_2nd_dash_led", int'(led_n), 0);
        rst = 1'b0;
        #1;
        check("async_rst_led_n", int'(led_n), 1);
        check("async_rst_busy", int'(busy), 0);
        check("async_rst_ready", int'(char_ready), 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_ready", int'(char_ready), 1);
        check("post_rst_led_n", int'(led_n), 1);
        play(8'h45, 1'b0);
        expect_runs("E_after_rst", '{1, 4, 12}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
